// File: rtl/ser_reg_file_burst_pkg.sv
// Shared definitions for the bit-serial burst register file: FSM encodings and
// elaboration-time sizing helpers.
package ser_reg_file_burst_pkg;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StAddr = 2'd1;
  localparam logic [1:0] StData = 2'd2;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ser_reg_file_burst_addr_dec.sv
// Combinational sparse-map decoder: serial address to one-hot register hit,
// plus read-only and unmapped flags.
module ser_reg_file_burst_addr_dec #(
  parameter int unsigned                  N_REG      = 5,
  parameter int unsigned                  ADDR_WIDTH = 8,
  parameter logic [N_REG*ADDR_WIDTH-1:0] ADDR_MAP   = 40'h5506A17834,
  parameter logic [N_REG-1:0]            RO_MASK    = 5'b10000
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic [N_REG-1:0]      hit_o,
  output logic                  ro_o,
  output logic                  unmapped_o
);

  always_comb begin
    hit_o = '0;
    for (int i = 0; i < N_REG; i++) begin
      hit_o[i] = (addr_i == ADDR_MAP[i*ADDR_WIDTH +: ADDR_WIDTH]);
    end
  end

  assign ro_o       = |(hit_o & RO_MASK);
  assign unmapped_o = ~|hit_o;

endmodule

// File: rtl/ser_reg_file_burst.sv
// Bit-serial register file with auto-increment bursts, atomic write commit,
// read snapshot, error pulse and parallel register outputs.
module ser_reg_file_burst
  import ser_reg_file_burst_pkg::*;
#(
  parameter int unsigned                  N_REG      = 5,
  parameter int unsigned                  ADDR_WIDTH = 8,
  parameter int unsigned                  DATA_WIDTH = 8,
  parameter logic [N_REG*ADDR_WIDTH-1:0] ADDR_MAP   = 40'h5506A17834,
  parameter logic [N_REG*DATA_WIDTH-1:0] INIT_VAL   = '0,
  parameter logic [N_REG-1:0]            RO_MASK    = 5'b10000
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        rd_en_i,
  input  logic                        wr_en_i,
  input  logic                        din_i,
  input  logic [N_REG*DATA_WIDTH-1:0] ro_data_i,
  output logic                        dout_o,
  output logic                        dout_vld_o,
  output logic                        busy_o,
  output logic                        err_o,
  output logic [N_REG-1:0]            wr_stb_o,
  output logic [N_REG*DATA_WIDTH-1:0] reg_q_o
);

  localparam int unsigned AW   = ADDR_WIDTH;
  localparam int unsigned DW   = DATA_WIDTH;
  localparam int unsigned CntW = clog2(max_u(AW, DW) + 1);

  logic [1:0]              state_q, state_d;
  logic                    dir_q, dir_d;  // 1 = write frame
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [AW-1:0]           addr_q, addr_d;
  logic [DW-2:0]           shadow_q, shadow_d;
  logic [DW-1:0]           snap_q, snap_d;
  logic                    dout_q, dout_d;
  logic                    vld_q, vld_d;
  logic                    err_q, err_d;
  logic [N_REG-1:0]        stb_q, stb_d;
  logic [N_REG-1:0]        hit_q, hit_d;
  logic                    ro_q, ro_d;
  logic                    unm_q, unm_d;
  logic [N_REG*DW-1:0]     regs_q, regs_d;

  logic                    last;
  logic                    cont;
  logic [AW-1:0]           addr_full;
  logic [AW-1:0]           dec_addr;
  logic [N_REG-1:0]        dec_hit;
  logic                    dec_ro;
  logic                    dec_unm;
  logic [DW-1:0]           rd_word;
  logic [DW-1:0]           wdata;

  assign last      = (cnt_q == CntW'(1));
  assign cont      = dir_q ? wr_en_i : rd_en_i;
  assign addr_full = {addr_q[AW-2:0], din_i};
  assign wdata     = {shadow_q, din_i};
  // First word decodes the freshly shifted address; later words the incremented one.
  assign dec_addr  = (state_q == StAddr) ? addr_full : addr_q + AW'(1);

  ser_reg_file_burst_addr_dec #(
    .N_REG      (N_REG),
    .ADDR_WIDTH (AW),
    .ADDR_MAP   (ADDR_MAP),
    .RO_MASK    (RO_MASK)
  ) u_addr_dec (
    .addr_i     (dec_addr),
    .hit_o      (dec_hit),
    .ro_o       (dec_ro),
    .unmapped_o (dec_unm)
  );

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < N_REG; i++) begin
      if (dec_hit[i]) begin
        rd_word = rd_word | (RO_MASK[i] ? ro_data_i[i*DW +: DW] : regs_q[i*DW +: DW]);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    shadow_d = shadow_q;
    snap_d   = snap_q;
    dout_d   = dout_q;
    vld_d    = vld_q;
    hit_d    = hit_q;
    ro_d     = ro_q;
    unm_d    = unm_q;
    regs_d   = regs_q;
    err_d    = 1'b0;
    stb_d    = '0;
    case (state_q)
      StIdle: begin
        if (rd_en_i || wr_en_i) begin
          state_d = StAddr;
          dir_d   = wr_en_i;
          cnt_d   = CntW'(AW);
        end
      end
      StAddr: begin
        addr_d = addr_full;
        cnt_d  = cnt_q - CntW'(1);
        if (last) begin
          state_d = StData;
          cnt_d   = CntW'(DW);
          hit_d   = dec_hit;
          ro_d    = dec_ro;
          unm_d   = dec_unm;
          if (!dir_q) begin
            dout_d = rd_word[DW-1];
            snap_d = rd_word << 1;
            vld_d  = 1'b1;
          end
        end
      end
      StData: begin
        cnt_d    = cnt_q - CntW'(1);
        shadow_d = wdata[DW-2:0];
        if (!dir_q) begin
          dout_d = snap_q[DW-1];
          snap_d = snap_q << 1;
        end
        if (last) begin
          err_d = unm_q | (dir_q & ro_q);
          if (dir_q) begin
            for (int i = 0; i < N_REG; i++) begin
              if (hit_q[i] && !RO_MASK[i]) begin
                regs_d[i*DW +: DW] = wdata;
                stb_d[i]           = 1'b1;
              end
            end
          end
          if (cont) begin
            addr_d = addr_q + AW'(1);
            cnt_d  = CntW'(DW);
            hit_d  = dec_hit;
            ro_d   = dec_ro;
            unm_d  = dec_unm;
            if (!dir_q) begin
              dout_d = rd_word[DW-1];
              snap_d = rd_word << 1;
            end
          end else begin
            state_d = StIdle;
            dout_d  = 1'b0;
            vld_d   = 1'b0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      dir_q    <= 1'b0;
      cnt_q    <= '0;
      addr_q   <= '0;
      shadow_q <= '0;
      snap_q   <= '0;
      dout_q   <= 1'b0;
      vld_q    <= 1'b0;
      err_q    <= 1'b0;
      stb_q    <= '0;
      hit_q    <= '0;
      ro_q     <= 1'b0;
      unm_q    <= 1'b0;
      for (int i = 0; i < N_REG; i++) begin
        regs_q[i*DW +: DW] <= RO_MASK[i] ? '0 : INIT_VAL[i*DW +: DW];
      end
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      shadow_q <= shadow_d;
      snap_q   <= snap_d;
      dout_q   <= dout_d;
      vld_q    <= vld_d;
      err_q    <= err_d;
      stb_q    <= stb_d;
      hit_q    <= hit_d;
      ro_q     <= ro_d;
      unm_q    <= unm_d;
      regs_q   <= regs_d;
    end
  end

  assign dout_o     = dout_q;
  assign dout_vld_o = vld_q;
  assign busy_o     = (state_q != StIdle);
  assign err_o      = err_q;
  assign wr_stb_o   = stb_q;
  assign reg_q_o    = regs_q;

endmodule

// File: tb/tb_ser_reg_file_burst.sv
// Directed bench for ser_reg_file_burst: serial writes, reads, bursts, RO and
// unmapped errors, and reset abort.
module tb_ser_reg_file_burst;

  logic        clk_i;
  logic        rst_ni;
  logic        rd_en_i;
  logic        wr_en_i;
  logic        din_i;
  logic [39:0] ro_data_i;
  logic        dout_o;
  logic        dout_vld_o;
  logic        busy_o;
  logic        err_o;
  logic [4:0]  wr_stb_o;
  logic [39:0] reg_q_o;

  int checks = 0;
  int errors = 0;

  ser_reg_file_burst dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .rd_en_i    (rd_en_i),
    .wr_en_i    (wr_en_i),
    .din_i      (din_i),
    .ro_data_i  (ro_data_i),
    .dout_o     (dout_o),
    .dout_vld_o (dout_vld_o),
    .busy_o     (busy_o),
    .err_o      (err_o),
    .wr_stb_o   (wr_stb_o),
    .reg_q_o    (reg_q_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_addr(input logic [7:0] a);
    for (int i = 7; i >= 0; i--) begin
      din_i = a[i];
      tick();
    end
    din_i = 1'b0;
  endtask

  task automatic write_frame(input logic [7:0] a, input logic [7:0] d, input logic both);
    wr_en_i = 1'b1;
    rd_en_i = both;
    tick();
    wr_en_i = 1'b0;
    rd_en_i = 1'b0;
    check("busy_after_start", 40'(busy_o), 40'h1);
    send_addr(a);
    check("wr_no_vld", 40'(dout_vld_o), 40'h0);
    for (int i = 7; i >= 0; i--) begin
      din_i = d[i];
      tick();
    end
    din_i = 1'b0;
  endtask

  task automatic start_read(input logic [7:0] a);
    rd_en_i = 1'b1;
    tick();
    rd_en_i = 1'b0;
    send_addr(a);
  endtask

  // Checks one 8-bit word on DOUT, one bit per cycle, MSB first.
  task automatic read_bits(input logic [7:0] exp, input logic cont);
    for (int i = 7; i >= 0; i--) begin
      check("rd_dout", 40'(dout_o), 40'(exp[i]));
      check("rd_vld", 40'(dout_vld_o), 40'h1);
      if (i == 0) rd_en_i = cont;
      tick();
    end
    rd_en_i = 1'b0;
  endtask

  initial begin
    rst_ni    = 1'b0;
    rd_en_i   = 1'b0;
    wr_en_i   = 1'b0;
    din_i     = 1'b0;
    ro_data_i = '0;
    #3;
    check("rst_reg_q", reg_q_o, 40'h0);
    check("rst_dout", 40'(dout_o), 40'h0);
    check("rst_vld", 40'(dout_vld_o), 40'h0);
    check("rst_busy", 40'(busy_o), 40'h0);
    check("rst_err", 40'(err_o), 40'h0);
    check("rst_stb", 40'(wr_stb_o), 40'h0);
    #10 rst_ni = 1'b1;
    tick();

    // Write 0xA5 to 0x78 (lane 1)
    write_frame(8'h78, 8'hA5, 1'b0);
    check("wr78_reg_q", reg_q_o, 40'h000000A500);
    check("wr78_stb", 40'(wr_stb_o), 40'h02);
    check("wr78_err", 40'(err_o), 40'h0);
    check("wr78_busy", 40'(busy_o), 40'h0);
    tick();
    check("wr78_stb_clear", 40'(wr_stb_o), 40'h0);

    // Read back 0x78
    start_read(8'h78);
    read_bits(8'hA5, 1'b0);
    check("rd78_vld_end", 40'(dout_vld_o), 40'h0);
    check("rd78_dout_end", 40'(dout_o), 40'h0);
    check("rd78_busy_end", 40'(busy_o), 40'h0);
    check("rd78_err", 40'(err_o), 40'h0);
    check("rd78_reg_q", reg_q_o, 40'h000000A500);
    tick();

    // Burst read from unmapped 0x54 into RO 0x55
    ro_data_i = 40'h3C00000000;
    start_read(8'h54);
    read_bits(8'h00, 1'b1);
    check("burst_err_w0", 40'(err_o), 40'h1);
    check("burst_busy_w0", 40'(busy_o), 40'h1);
    read_bits(8'h3C, 1'b0);
    check("burst_err_w1", 40'(err_o), 40'h0);
    check("burst_vld_end", 40'(dout_vld_o), 40'h0);
    check("burst_busy_end", 40'(busy_o), 40'h0);
    tick();

    // Write to RO 0x55
    write_frame(8'h55, 8'hFF, 1'b0);
    check("wrro_reg_q", reg_q_o, 40'h000000A500);
    check("wrro_stb", 40'(wr_stb_o), 40'h0);
    check("wrro_err", 40'(err_o), 40'h1);
    tick();
    check("wrro_err_clear", 40'(err_o), 40'h0);

    // Reset in the middle of a write to 0x34 aborts it
    wr_en_i = 1'b1;
    tick();
    wr_en_i = 1'b0;
    send_addr(8'h34);
    for (int i = 0; i < 3; i++) begin
      din_i = 1'b1;
      tick();
    end
    rst_ni = 1'b0;
    #2;
    check("abort_reg_q", reg_q_o, 40'h0);
    check("abort_busy", 40'(busy_o), 40'h0);
    check("abort_err", 40'(err_o), 40'h0);
    check("abort_stb", 40'(wr_stb_o), 40'h0);
    #2 rst_ni = 1'b1;
    din_i = 1'b0;
    tick();
    write_frame(8'h34, 8'h5A, 1'b0);
    check("wr34_reg_q", reg_q_o, 40'h000000005A);
    check("wr34_stb", 40'(wr_stb_o), 40'h01);
    check("wr34_err", 40'(err_o), 40'h0);
    tick();

    // RD_EN and WR_EN together at start -> write frame to 0xA1
    write_frame(8'hA1, 8'h11, 1'b1);
    check("both_reg_q", reg_q_o, 40'h000011005A);
    check("both_stb", 40'(wr_stb_o), 40'h04);
    check("both_vld", 40'(dout_vld_o), 40'h0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
